// File: rtl/usb_pkg.sv
// usb_pkg: shared state encoding, default widths and endpoint-index sizing
// for the USB endpoint transmit arbiter.
package usb_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, XFER, GAP} arb_state_t;
    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 7;
    function automatic int ep_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/usb_rr_picker.sv
// usb_rr_picker: combinational round-robin selector; requests under prio_mask
// win outright (lowest index first), the rest rotate starting after last_grant.
module usb_rr_picker
    import usb_pkg::*;
#(
    parameter int NUM_EP = 4,
    parameter int IDX_W  = ep_idx_w(NUM_EP)
) (
    input  logic [NUM_EP-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    input  logic [NUM_EP-1:0] prio_mask,
    output logic [IDX_W-1:0]  winner,
    output logic              valid
);
    logic [NUM_EP-1:0] pri, rr;
    assign pri   = req & prio_mask;
    assign rr    = req & ~prio_mask;
    assign valid = |req;
    always_comb begin
        winner = '0;
        for (int i = NUM_EP; i >= 1; i--)
            if (rr[(int'(last_grant) + i) % NUM_EP]) winner = IDX_W'((int'(last_grant) + i) % NUM_EP);
        for (int i = NUM_EP - 1; i >= 0; i--)
            if (pri[i]) winner = IDX_W'(i);
    end
endmodule

// File: rtl/usb_ep_tx_arbiter.sv
// usb_ep_tx_arbiter: shares the USB transmit byte path among NUM_EP endpoints.
// Define USB_ARB_EP0_PRIO_EN to give endpoint 0 strict priority over the round-robin.
module usb_ep_tx_arbiter
    import usb_pkg::*;
#(
    parameter int NUM_EP     = 4,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int GAP_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_EP-1:0]         ep_req,
    input  logic [NUM_EP*LEN_W-1:0]   ep_len,
    input  logic [NUM_EP*DATA_W-1:0]  ep_data,
    output logic [NUM_EP-1:0]         ep_rd,
    output logic [NUM_EP-1:0]         ep_done,
    output logic                      tx_valid,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_last,
    output logic [$clog2(NUM_EP)-1:0] tx_ep,
    input  logic                      tx_ready,
    output logic                      busy
);
    localparam int IDX_W = ep_idx_w(NUM_EP);
    localparam int GW    = $clog2(GAP_CYCLES + 1);
`ifdef USB_ARB_EP0_PRIO_EN
    localparam logic [NUM_EP-1:0] PRIO_MASK = NUM_EP'(1);
`else
    localparam logic [NUM_EP-1:0] PRIO_MASK = '0;
`endif
    arb_state_t state, state_nx;
    logic [IDX_W-1:0] win, last_grant, pick;
    logic pick_vld, hs, fin;
    logic [LEN_W-1:0] cnt, len;
    logic [GW-1:0] gap_cnt;
    logic [NUM_EP-1:0] win_oh;

    usb_rr_picker #(.NUM_EP(NUM_EP), .IDX_W(IDX_W)) u_picker (
        .req       (ep_req),
        .last_grant(last_grant),
        .prio_mask (PRIO_MASK),
        .winner    (pick),
        .valid     (pick_vld)
    );

    assign len      = ep_len[int'(win)*LEN_W +: LEN_W];
    assign win_oh   = NUM_EP'(1) << win;
    assign tx_valid = state == XFER;
    assign tx_data  = tx_valid ? ep_data[int'(win)*DATA_W +: DATA_W] : '0;
    assign tx_last  = tx_valid && cnt == LEN_W'(1);
    assign tx_ep    = win;
    assign hs       = tx_valid && tx_ready;
    assign ep_rd    = hs ? win_oh : '0;
    assign busy     = state != IDLE;
    // a zero-length packet completes straight out of GRANT
    assign fin      = (state == GRANT && len == '0) || (hs && tx_last);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = pick_vld ? GRANT : IDLE;
            GRANT:   state_nx = (len == '0) ? GAP : XFER;
            XFER:    state_nx = (hs && tx_last) ? GAP : XFER;
            GAP:     state_nx = (gap_cnt == GW'(GAP_CYCLES - 1)) ? IDLE : GAP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            win        <= '0;
            last_grant <= IDX_W'(NUM_EP - 1);
            cnt        <= '0;
            gap_cnt    <= '0;
            ep_done    <= '0;
        end else begin
            state   <= state_nx;
            gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;
            ep_done <= fin ? win_oh : '0;
            if (state == IDLE && pick_vld) win <= pick;
            if (state == GRANT) cnt <= len;
            else if (hs && cnt != '0) cnt <= cnt - LEN_W'(1);
            // priority grants leave the rotation position untouched
            if (hs && tx_last && !PRIO_MASK[win]) last_grant <= win;
        end
    end
endmodule

// File: tb/tb_usb_ep_tx_arbiter.sv
// tb_usb_ep_tx_arbiter: table-driven single-packet vectors plus hand sequences
// for round-robin, backpressure, reset and EP0 priority, checked via a byte scoreboard.
module tb_usb_ep_tx_arbiter;
    localparam int NUM_EP = 4, DATA_W = 8, LEN_W = 7, GAP_CYCLES = 2;

    typedef struct {int ep; logic [7:0] data; logic last;} exp_t;
    typedef struct {int ep; int len; int lat;} vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NUM_EP-1:0] ep_req = '0;
    logic [NUM_EP*LEN_W-1:0] ep_len = '0;
    logic [NUM_EP*DATA_W-1:0] ep_data;
    logic [NUM_EP-1:0] ep_rd, ep_done;
    logic tx_valid, tx_last, busy;
    logic tx_ready = 1'b1;
    logic [DATA_W-1:0] tx_data;
    logic [1:0] tx_ep;
    logic [7:0] pos [NUM_EP];

    int checks, passed, cyc;
    int hs_cnt, rd_cnt, first_v, last_hs, done_c, idle_c, n_done, stall_n;
    logic [NUM_EP-1:0] done_mask, rd_pend;
    logic hold, stalling, st_last;
    logic [7:0] st_data;
    int hs_log[$];
    exp_t q[$];

    usb_ep_tx_arbiter #(.NUM_EP(NUM_EP), .DATA_W(DATA_W), .LEN_W(LEN_W), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .ep_req(ep_req), .ep_len(ep_len), .ep_data(ep_data),
        .ep_rd(ep_rd), .ep_done(ep_done), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_last(tx_last), .tx_ep(tx_ep), .tx_ready(tx_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // endpoint buffers: each presents ep*16 + number of bytes already popped
    always_comb
        for (int e = 0; e < NUM_EP; e++) ep_data[e*DATA_W +: DATA_W] = 8'(e * 16) + pos[e];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic clear_stats();
        hs_cnt = 0; rd_cnt = 0; first_v = -1; last_hs = -1; done_c = -1; idle_c = -1;
        n_done = 0; stall_n = 0; done_mask = '0; stalling = 1'b0; hs_log.delete();
    endtask

    task automatic sample();
        exp_t e;
        rd_cnt += $countones(ep_rd);
        rd_pend = ep_rd;
        if (tx_valid && first_v < 0) first_v = cyc;
        if (tx_valid && tx_ready) begin
            hs_cnt++;
            hs_log.push_back(cyc);
            if (tx_last) last_hs = cyc;
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_byte: got ep %0d data %0h, scoreboard empty", tx_ep, tx_data);
            end else begin
                e = q.pop_front();
                chk("tx_ep", int'(tx_ep), e.ep);
                chk("tx_data", int'(tx_data), int'(e.data));
                chk("tx_last", int'(tx_last), int'(e.last));
                chk("ep_rd", int'(ep_rd), 1 << e.ep);
            end
        end
        if (tx_valid && !tx_ready) begin
            if (stalling) begin
                chk("stall_data", int'(tx_data), int'(st_data));
                chk("stall_last", int'(tx_last), int'(st_last));
            end
            chk("stall_rd", int'(ep_rd), 0);
            stalling = 1'b1; st_data = tx_data; st_last = tx_last; stall_n++;
        end else stalling = 1'b0;
        if (ep_done != '0) begin
            n_done++;
            done_mask |= ep_done;
            if (done_c < 0) done_c = cyc;
            if (!hold) ep_req &= ~ep_done;
        end
        if (!busy && done_c >= 0 && idle_c < 0) idle_c = cyc;
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        for (int e = 0; e < NUM_EP; e++) if (rd_pend[e]) pos[e]++;
    endtask

    task automatic post(input int ep, input int len);
        ep_len[ep*LEN_W +: LEN_W] = LEN_W'(len);
        for (int k = 0; k < len; k++) q.push_back('{ep, 8'(ep * 16) + pos[ep] + 8'(k), k == len - 1});
        ep_req[ep] = 1'b1;
    endtask

    task automatic wait_done(input int n, input int bound);
        for (int t = 0; t < bound && n_done < n; t++) tick();
        if (n_done < n) chk("done_timeout", n_done, n);
    endtask

    task automatic wait_idle(input int bound);
        for (int t = 0; t < bound && idle_c < 0; t++) tick();
        if (idle_c < 0) chk("idle_timeout", idle_c, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ep_req = '0; tx_ready = 1'b1; hold = 1'b0;
        foreach (pos[e]) pos[e] = '0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        vec_t v[6];
        int start;
        bit repost;
        v[0] = '{1, 3, 2};
        v[1] = '{0, 1, 2};
        v[2] = '{2, 0, -1};
        v[3] = '{3, 5, 2};
        v[4] = '{2, 4, 2};
        v[5] = '{1, 127, 2};
        checks = 0; passed = 0; cyc = 0; hold = 1'b0;
        foreach (pos[e]) pos[e] = '0;
        clear_stats();

        @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_tx_valid", int'(tx_valid), 0);
        chk("reset_ep_done", int'(ep_done), 0);
        chk("reset_tx_ep", int'(tx_ep), 0);
        chk("reset_tx_data", int'(tx_data), 0);
        do_reset();

        for (int i = 0; i < 6; i++) begin
            clear_stats();
            start = cyc;
            post(v[i].ep, v[i].len);
            wait_done(1, 400);
            wait_idle(20);
            chk("latency", first_v < 0 ? -1 : first_v - start, v[i].lat);
            chk("bytes", hs_cnt, v[i].len);
            chk("rd_pulses", rd_cnt, v[i].len);
            chk("done_mask", int'(done_mask), 1 << v[i].ep);
            chk("done_timing", done_c - (v[i].len > 0 ? last_hs : start + 1), 1);
            chk("gap_to_idle", idle_c - done_c, GAP_CYCLES);
            if (v[i].len > 0) chk("throughput", last_hs - first_v, v[i].len - 1);
            chk("queue_empty", q.size(), 0);
        end

        do_reset();
        clear_stats();
        for (int e = 0; e < NUM_EP; e++) post(e, 1);
        repost = 0;
        for (int t = 0; t < 200 && n_done < 5; t++) begin
            tick();
            if (!repost && done_mask[0]) begin
                post(0, 1);
                repost = 1;
            end
        end
        chk("rr_grants", hs_log.size(), 5);
        for (int i = 1; i < hs_log.size(); i++) chk("rr_spacing", hs_log[i] - hs_log[i-1], GAP_CYCLES + 3);
        chk("rr_queue_empty", q.size(), 0);

        do_reset();
        clear_stats();
        post(0, 2);
        for (int t = 0; t < 20 && hs_cnt < 1; t++) tick();
        tx_ready = 1'b0;
        repeat (5) tick();
        tx_ready = 1'b1;
        wait_done(1, 20);
        chk("bp_stall_cycles", stall_n, 5);
        chk("bp_bytes", hs_cnt, 2);
        chk("bp_rd_pulses", rd_cnt, 2);

        do_reset();
        clear_stats();
        post(0, 1);
        wait_done(1, 20);
        wait_idle(20);
        clear_stats();
        post(1, 4);
        for (int t = 0; t < 20 && hs_cnt < 1; t++) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_tx_valid", int'(tx_valid), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_tx_last", int'(tx_last), 0);
        chk("rst_tx_ep", int'(tx_ep), 0);
        chk("rst_ep_rd", int'(ep_rd), 0);
        chk("rst_ep_done", int'(ep_done), 0);
        chk("rst_busy", int'(busy), 0);
        ep_req = '0;
        q.delete();
        foreach (pos[e]) pos[e] = '0;
        repeat (3) tick();
        chk("rst_no_done", n_done, 0);
        rst_n = 1'b1;
        clear_stats();
        post(0, 1);
        post(2, 1);
        wait_done(2, 40);
        chk("post_rst_bytes", hs_cnt, 2);
        chk("post_rst_queue_empty", q.size(), 0);

        do_reset();
        clear_stats();
        hold = 1'b1;
        ep_len[0 +: LEN_W] = LEN_W'(1);
        ep_len[3*LEN_W +: LEN_W] = LEN_W'(1);
`ifdef USB_ARB_EP0_PRIO_EN
        for (int k = 0; k < 4; k++) q.push_back('{0, 8'(k), 1'b1});
`else
        q.push_back('{0, 8'h00, 1'b1});
        q.push_back('{3, 8'h30, 1'b1});
        q.push_back('{0, 8'h01, 1'b1});
        q.push_back('{3, 8'h31, 1'b1});
`endif
        ep_req = 4'b1001;
        for (int t = 0; t < 100 && n_done < 4; t++) tick();
        ep_req = '0;
        hold = 1'b0;
        chk("prio_grants", hs_cnt, 4);
        chk("prio_queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
